// File: rtl/capture_pkg.sv
// Shared encodings for the trigger/capture debug blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package capture_pkg;

  // Trigger edge selection as driven on the trig_mode pins.
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } trig_mode_t;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sig_capture_sync_edge.sv
// Synchronises an asynchronous 1-bit input and flags the mode-selected edge.
// Latency: an input toggle shows up on hit after the 2nd clk edge, consumed at the 3rd.
// Backpressure: none; hit is a single-cycle level per edge.
//
// Ports: clk, rst_n (async active-low), async_in (unsynchronised source),
//        mode (trig_mode encoding), hit (one cycle per selected edge).
module sync_edge
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       async_in,
  input  logic [1:0] mode,
  output logic       hit
);

  logic s1, s2, s3;
  logic rise, fall;

  // s1/s2 form the synchroniser; s3 is history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    hit = 1'b0;
    case (trig_mode_t'(mode))
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sig_capture.sv
// Trigger-qualified capture of a data stream into a DEPTH-word buffer with readout.
// Latency: capture starts 3 clk edges after a trig_in toggle; rd_data is 1 clk after rd_addr.
// Backpressure: none; the stream is sampled every clk, arm/abort are single-cycle pulses.
//
// Ports: clk, rst_n (async active-low); trig_in, data_in (asynchronous sources);
//        trig_mode (edge select), arm/abort (control pulses); rd_addr -> rd_data (readout);
//        armed/busy/done (state flags), trig_count (saturating qualifying-edge count).
module sig_capture
  import capture_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig_in,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    trig_mode,
  input  logic          arm,
  input  logic          abort,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          armed,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] trig_count
);

  logic          hit;
  logic [DW-1:0] d1, d2, d3;
  cap_state_t    state, state_nxt;
  logic [AW-1:0] wptr, wptr_nxt;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          cnt_clr, cnt_inc;
  logic [DW-1:0] mem [DEPTH];

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (trig_in),
    .mode     (trig_mode),
    .hit      (hit)
  );

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    wr_addr   = wptr;
    wr_en     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      // Abort beats everything, including a same-cycle arm or hit.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state_nxt = ARMED;
            wptr_nxt  = '0;
            cnt_clr   = 1'b1;
          end
        end
        ARMED: begin
          if (hit) begin
            state_nxt = CAPTURE;
            wr_en     = 1'b1;
            wr_addr   = '0;
            wptr_nxt  = AW'(1);
            cnt_inc   = 1'b1;
          end
        end
        CAPTURE: begin
          wr_en = 1'b1;
          // Pointer parks on the last address instead of wrapping.
          if (wptr == AW'(DEPTH - 1)) state_nxt = DONE;
          else                        wptr_nxt  = wptr + AW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_count <= '0;
      rd_data    <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
    end else begin
      // Three data stages so the stored word lines up with the trigger pipeline.
      d1         <= data_in;
      d2         <= d1;
      d3         <= d2;
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      // Flags decoded from next state so they are clean flop outputs.
      armed      <= (state_nxt == ARMED);
      busy       <= (state_nxt == CAPTURE);
      done       <= (state_nxt == DONE);
      rd_data    <= mem[rd_addr];
      if (cnt_clr)                          trig_count <= '0;
      else if (cnt_inc && trig_count != '1) trig_count <= trig_count + CW'(1);
    end
  end

  // Buffer has no reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= d3;
  end

endmodule
